// File: rtl/mel_accum_if.sv
// Bin stream in, register-file write port and status out, for the mel accumulator.
interface mel_accum_if #(
  parameter int PW = 32,
  parameter int WW = 12,
  parameter int AW = 45
);
  logic          frame_start;
  logic          bin_valid;
  logic          bin_ready;
  logic [PW-1:0] bin_power;
  logic [4:0]    bin_seg;
  logic [WW-1:0] bin_wt;
  logic          bin_last;
  logic [4:0]    regmel_addr;
  logic [AW-1:0] regmel_in;
  logic          regmel_wren;
  logic          mel_done;
  logic          seg_err;

  // Producer of bins / consumer of band writes.
  modport master (
    output frame_start, bin_valid, bin_power, bin_seg, bin_wt, bin_last,
    input  bin_ready, regmel_addr, regmel_in, regmel_wren, mel_done, seg_err
  );

  // The accumulator itself.
  modport slave (
    input  frame_start, bin_valid, bin_power, bin_seg, bin_wt, bin_last,
    output bin_ready, regmel_addr, regmel_in, regmel_wren, mel_done, seg_err
  );
endinterface

// File: rtl/mel_accum.sv
// Mel filterbank accumulator.
// Bins arrive in ascending segment order. A bin in segment s adds its rising
// share (power*w) to band s and its falling share (power*(1-w)) to band s-1.
// Two running accumulators are therefore enough: acc_prev holds band s-1 and
// acc_cur holds band s. When the segment advances, band s-1 is complete and is
// written out. The leftover bands are flushed after the last bin, so that every
// address 0..NBANDS-1 is written exactly once per frame, in ascending order.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for frame_start, bin_ready low
//  S_ACC   | accepting bins, at most one band write per accepted bin
//  S_FLUSH | writing the remaining bands, one per cycle, up to NBANDS-1
//  S_DONE  | raises mel_done for one cycle, then returns to S_IDLE
module mel_accum #(
  parameter int NBANDS = 23,
  parameter int PW     = 32,
  parameter int WW     = 12,
  parameter int AW     = 45
) (
  input  logic        clk,
  input  logic        reset,
  mel_accum_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0]  NB        = 5'(NBANDS);
  localparam logic [4:0]  LAST_ADDR = 5'(NBANDS - 1);
  localparam logic [WW:0] UNITY     = {1'b1, {WW{1'b0}}};

  logic [1:0]    state;
  logic [4:0]    seg_reg;
  logic [4:0]    flush_addr;
  logic [AW-1:0] acc_prev;
  logic [AW-1:0] acc_cur;

  logic          accept;
  logic [WW:0]   wt_lo;
  logic [AW-1:0] power_x;
  logic [AW-1:0] wt_hi_x;
  logic [AW-1:0] wt_lo_x;
  logic [AW-1:0] p_hi;
  logic [AW-1:0] p_lo;

  logic          seg_same;
  logic          seg_adv;
  logic [4:0]    seg_nxt;
  logic [AW-1:0] acc_prev_nxt;
  logic [AW-1:0] acc_cur_nxt;
  logic          wr_acc;
  logic          err_acc;
  logic [4:0]    flush_start;
  logic [AW-1:0] flush_data;

  // Saturating add. A band energy pinned at full scale is still a useful
  // reading for the log stage, whereas a wrapped value is not.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AW] ? {AW{1'b1}} : s[AW-1:0];
  endfunction

  assign bus.bin_ready = (state == S_ACC);
  assign accept        = bus.bin_valid && (state == S_ACC);

  // Split the bin power into its rising (p_hi) and falling (p_lo) shares.
  // The falling weight needs WW+1 bits, because w=0 gives a falling weight of unity.
  always_comb begin
    wt_lo   = UNITY - {1'b0, bus.bin_wt};
    power_x = {{(AW-PW){1'b0}}, bus.bin_power};
    wt_hi_x = {{(AW-WW){1'b0}}, bus.bin_wt};
    wt_lo_x = {{(AW-WW-1){1'b0}}, wt_lo};
    p_hi    = power_x * wt_hi_x;
    p_lo    = power_x * wt_lo_x;
  end

  // Classify the incoming segment against seg_reg and work out the
  // accumulator update for the bin that is being accepted.
  always_comb begin
    seg_same     = (bus.bin_seg == seg_reg);
    seg_adv      = ({1'b0, bus.bin_seg} == ({1'b0, seg_reg} + 6'd1)) &&
                   (bus.bin_seg <= NB);
    seg_nxt      = seg_reg;
    acc_prev_nxt = acc_prev;
    acc_cur_nxt  = acc_cur;
    wr_acc       = 1'b0;
    err_acc      = 1'b0;
    if (seg_same) begin
      if (seg_reg != 5'd0) acc_prev_nxt = sat_add(acc_prev, p_lo);
      if (seg_reg < NB)    acc_cur_nxt  = sat_add(acc_cur, p_hi);
    end else if (seg_adv) begin
      wr_acc       = (seg_reg != 5'd0);
      acc_prev_nxt = sat_add(acc_cur, p_lo);
      acc_cur_nxt  = (bus.bin_seg < NB) ? p_hi : '0;
      seg_nxt      = bus.bin_seg;
    end else begin
      err_acc = 1'b1;
    end
  end

  // Flush begins at the oldest band that has not been written yet. That band is
  // seg_reg-1 while a segment is open, and band 0 when no bin advanced past segment 0.
  always_comb begin
    flush_start = (seg_nxt != 5'd0) ? (seg_nxt - 5'd1) : 5'd0;
    flush_data  = '0;
    if ((seg_reg != 5'd0) && (flush_addr == (seg_reg - 5'd1)))
      flush_data = acc_prev;
    else if ((seg_reg < NB) && (flush_addr == seg_reg))
      flush_data = acc_cur;
  end

  // Frame sequencing, accumulator state and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      seg_reg         <= '0;
      flush_addr      <= '0;
      acc_prev        <= '0;
      acc_cur         <= '0;
      bus.regmel_addr <= '0;
      bus.regmel_in   <= '0;
      bus.regmel_wren <= 1'b0;
      bus.mel_done    <= 1'b0;
      bus.seg_err     <= 1'b0;
    end else begin
      bus.regmel_wren <= 1'b0;
      bus.mel_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.frame_start) begin
            state       <= S_ACC;
            seg_reg     <= '0;
            acc_prev    <= '0;
            acc_cur     <= '0;
            bus.seg_err <= 1'b0;
          end
        end
        S_ACC: begin
          if (accept) begin
            seg_reg  <= seg_nxt;
            acc_prev <= acc_prev_nxt;
            acc_cur  <= acc_cur_nxt;
            if (err_acc) bus.seg_err <= 1'b1;
            if (wr_acc) begin
              bus.regmel_wren <= 1'b1;
              bus.regmel_addr <= seg_reg - 5'd1;
              bus.regmel_in   <= acc_prev;
            end
            if (bus.bin_last) begin
              state      <= S_FLUSH;
              flush_addr <= flush_start;
            end
          end
        end
        S_FLUSH: begin
          bus.regmel_wren <= 1'b1;
          bus.regmel_addr <= flush_addr;
          bus.regmel_in   <= flush_data;
          if (flush_addr == LAST_ADDR)
            state <= S_DONE;
          else
            flush_addr <= flush_addr + 5'd1;
        end
        default: begin
          bus.mel_done <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mel_accum.sv
// Directed bench for mel_accum: reset, nominal frame, saturation, early end,
// illegal segment, and gaps with stray frame_start pulses.
module tb_mel_accum;
  localparam int NB = 23;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mel_accum_if bus ();

  mel_accum dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Counts one comparison and reports it when the observed value differs.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write and done monitor, sampled on the falling edge.
  logic [4:0]  wa [0:511];
  logic [44:0] wd [0:511];
  int wr_n    = 0;
  int done_n  = 0;
  int done_at = 0;

  always @(negedge clk) begin
    if (bus.regmel_wren && wr_n < 512) begin
      wa[wr_n] = bus.regmel_addr;
      wd[wr_n] = bus.regmel_in;
      wr_n++;
    end
    if (bus.mel_done) begin
      done_n++;
      done_at = wr_n;
    end
  end

  logic [44:0] exp_d [0:NB-1];

  task automatic set_exp_all(input logic [44:0] v);
    for (int i = 0; i < NB; i++) exp_d[i] = v;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  // Presents one bin and holds it until it is accepted. Call this task at a falling edge.
  task automatic send_bin(input logic [4:0] seg, input logic [31:0] pw,
                          input logic [11:0] wt, input logic last);
    int n;
    n = 0;
    bus.bin_valid = 1'b1;
    bus.bin_seg   = seg;
    bus.bin_power = pw;
    bus.bin_wt    = wt;
    bus.bin_last  = last;
    while (!bus.bin_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
    @(negedge clk);
    bus.bin_valid = 1'b0;
    bus.bin_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_n == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_timeout"}, 64'(n < 200), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int wb, input int db);
    chk({tag, "_nwr"}, 64'(wr_n - wb), 64'(NB));
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(wa[wb+i]), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(wd[wb+i]), 64'(exp_d[i]));
    end
    chk({tag, "_ndone"}, 64'(done_n - db), 64'd1);
    chk({tag, "_done_pos"}, 64'(done_at), 64'(wb + NB));
  endtask

  task automatic check_quiet_outputs(input string tag);
    chk({tag, "_wren"},  64'(bus.regmel_wren), 64'd0);
    chk({tag, "_addr"},  64'(bus.regmel_addr), 64'd0);
    chk({tag, "_data"},  64'(bus.regmel_in),   64'd0);
    chk({tag, "_done"},  64'(bus.mel_done),    64'd0);
    chk({tag, "_err"},   64'(bus.seg_err),     64'd0);
    chk({tag, "_ready"}, 64'(bus.bin_ready),   64'd0);
  endtask

  int wb, db;

  initial begin
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.bin_valid   = 1'b0;
    bus.bin_power   = '0;
    bus.bin_seg     = '0;
    bus.bin_wt      = '0;
    bus.bin_last    = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet_outputs("rst0");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(bus.bin_ready), 64'd0);

    // T1: reset in the middle of a frame with a bin being accepted
    start_frame();
    send_bin(5'd0, 32'd1, 12'd2048, 1'b0);
    send_bin(5'd1, 32'd1, 12'd2048, 1'b0);
    send_bin(5'd2, 32'd1, 12'd2048, 1'b0);
    bus.bin_valid = 1'b1;
    bus.bin_seg   = 5'd3;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_quiet_outputs("t1_rst");
    @(negedge clk);
    reset = 1'b0;
    wb = wr_n;
    db = done_n;
    repeat (40) @(negedge clk);
    chk("t1_ready_idle", 64'(bus.bin_ready), 64'd0);
    chk("t1_no_write", 64'(wr_n - wb), 64'd0);
    chk("t1_no_done", 64'(done_n - db), 64'd0);
    bus.bin_valid = 1'b0;
    @(negedge clk);

    // T2: nominal frame, half weight on every bin
    wb = wr_n;
    db = done_n;
    start_frame();
    for (int s = 0; s <= NB; s++) send_bin(5'(s), 32'd1, 12'd2048, s == NB);
    wait_done("t2", db);
    set_exp_all(45'd4096);
    check_frame("t2", wb, db);
    chk("t2_err", 64'(bus.seg_err), 64'd0);

    // T3: band 0 saturates from three full-power falling shares
    wb = wr_n;
    db = done_n;
    start_frame();
    for (int k = 0; k < 3; k++) send_bin(5'd1, 32'hFFFF_FFFF, 12'd0, 1'b0);
    send_bin(5'd1, 32'd0, 12'd0, 1'b1);
    wait_done("t3", db);
    set_exp_all(45'd0);
    exp_d[0] = 45'h1FFF_FFFF_FFFF;
    check_frame("t3", wb, db);
    chk("t3_err", 64'(bus.seg_err), 64'd0);

    // T4: frame ends at segment 5, so bands 4 and 5 come from the flush
    wb = wr_n;
    db = done_n;
    start_frame();
    for (int s = 0; s <= 5; s++) send_bin(5'(s), 32'd10, 12'd1024, s == 5);
    wait_done("t4", db);
    set_exp_all(45'd0);
    for (int i = 0; i <= 4; i++) exp_d[i] = 45'd40960;
    exp_d[5] = 45'd10240;
    check_frame("t4", wb, db);

    // T5: a bin for segment 4 arrives while seg_reg is 2
    wb = wr_n;
    db = done_n;
    start_frame();
    send_bin(5'd0, 32'd10, 12'd1024, 1'b0);
    send_bin(5'd1, 32'd10, 12'd1024, 1'b0);
    send_bin(5'd2, 32'd10, 12'd1024, 1'b0);
    chk("t5_err_before", 64'(bus.seg_err), 64'd0);
    send_bin(5'd4, 32'd1000, 12'd0, 1'b0);
    chk("t5_err_set", 64'(bus.seg_err), 64'd1);
    repeat (2) @(negedge clk);
    chk("t5_no_extra_write", 64'(wr_n - wb), 64'd1);
    send_bin(5'd3, 32'd10, 12'd1024, 1'b1);
    wait_done("t5", db);
    set_exp_all(45'd0);
    for (int i = 0; i <= 2; i++) exp_d[i] = 45'd40960;
    exp_d[3] = 45'd10240;
    check_frame("t5", wb, db);
    chk("t5_err_sticky", 64'(bus.seg_err), 64'd1);

    // T6: nominal frame again, with valid gaps and stray frame_start pulses
    wb = wr_n;
    db = done_n;
    start_frame();
    chk("t6_err_cleared", 64'(bus.seg_err), 64'd0);
    for (int s = 0; s <= NB; s++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        bus.frame_start = (g == 1);
        @(negedge clk);
        bus.frame_start = 1'b0;
      end
      bus.frame_start = (s % 5 == 2);
      send_bin(5'(s), 32'd1, 12'd2048, s == NB);
      bus.frame_start = 1'b0;
    end
    wait_done("t6", db);
    set_exp_all(45'd4096);
    check_frame("t6", wb, db);
    chk("t6_err", 64'(bus.seg_err), 64'd0);
    chk("t6_idle_ready", 64'(bus.bin_ready), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
